// File: rtl/decode_stage.sv
// Instruction-decode stage: drives regfile read ports, bypasses writeback data,
// stalls on load-use hazards and registers the decoded ID/EX bundle.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  output logic              id_ready,
  output logic [ADDR_W-1:0] ReadRegister1,
  output logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_dest,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [2:0]        ex_alu_op,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Register $0 is never forwarded: it always reads as the regfile value.
  function automatic logic [DATA_W-1:0] bypass(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] rf_data,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    if (wr_en && (wr_addr == src) && (src != {ADDR_W{1'b0}})) begin
      return wr_data;
    end else begin
      return rf_data;
    end
  endfunction

  logic [5:0]        op_s;
  logic [5:0]        funct_s;
  logic [ADDR_W-1:0] rs_s;
  logic [ADDR_W-1:0] rt_s;
  logic [ADDR_W-1:0] rd_s;

  assign op_s          = if_instr[31:26];
  assign rs_s          = if_instr[25:21];
  assign rt_s          = if_instr[20:16];
  assign rd_s          = if_instr[15:11];
  assign funct_s       = if_instr[5:0];
  assign ReadRegister1 = rs_s;
  assign ReadRegister2 = rt_s;

  logic [ADDR_W-1:0] dec_dest_s;
  logic              dec_rw_raw_s;
  logic              dec_rw_s;
  logic              dec_mr_s;
  logic              dec_mw_s;
  logic [2:0]        dec_alu_s;
  logic              dec_ill_s;
  logic [DATA_W-1:0] dec_imm_s;
  logic [DATA_W-1:0] dec_rs_data_s;
  logic [DATA_W-1:0] dec_rt_data_s;

  always_comb begin
    dec_dest_s   = {ADDR_W{1'b0}};
    dec_rw_raw_s = 1'b0;
    dec_mr_s     = 1'b0;
    dec_mw_s     = 1'b0;
    dec_alu_s    = ALU_ADD;
    dec_ill_s    = 1'b0;
    case (op_s)
      6'h00: begin
        dec_dest_s   = rd_s;
        dec_rw_raw_s = 1'b1;
        case (funct_s)
          6'h20:   dec_alu_s = ALU_ADD;
          6'h22:   dec_alu_s = ALU_SUB;
          6'h24:   dec_alu_s = ALU_AND;
          6'h25:   dec_alu_s = ALU_OR;
          6'h2A:   dec_alu_s = ALU_SLT;
          default: begin
            dec_ill_s    = 1'b1;
            dec_rw_raw_s = 1'b0;
          end
        endcase
      end
      6'h08: begin
        dec_dest_s   = rt_s;
        dec_rw_raw_s = 1'b1;
      end
      6'h23: begin
        dec_dest_s   = rt_s;
        dec_rw_raw_s = 1'b1;
        dec_mr_s     = 1'b1;
      end
      6'h2B:   dec_mw_s  = 1'b1;
      6'h04:   dec_alu_s = ALU_SUB;
      default: dec_ill_s = 1'b1;
    endcase
  end

  assign dec_rw_s      = dec_rw_raw_s && (dec_dest_s != {ADDR_W{1'b0}});
  assign dec_imm_s     = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};
  assign dec_rs_data_s = bypass(rs_s, ReadData1, wb_regwrite, wb_waddr, wb_wdata);
  assign dec_rt_data_s = bypass(rt_s, ReadData2, wb_regwrite, wb_waddr, wb_wdata);

  logic              ex_valid_q,    ex_valid_d;
  logic [DATA_W-1:0] ex_rs_data_q,  ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q,  ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,      ex_imm_d;
  logic [ADDR_W-1:0] ex_dest_q,     ex_dest_d;
  logic              ex_regwrite_q, ex_regwrite_d;
  logic              ex_memread_q,  ex_memread_d;
  logic              ex_memwrite_q, ex_memwrite_d;
  logic [2:0]        ex_alu_op_q,   ex_alu_op_d;
  logic              ex_illegal_q,  ex_illegal_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic adv_s;
  logic hazard_s;

  // A load in EX whose destination feeds this instruction must drain first.
  assign hazard_s = if_valid && ex_valid_q && ex_memread_q &&
                    (ex_dest_q != {ADDR_W{1'b0}}) &&
                    ((ex_dest_q == rs_s) || (ex_dest_q == rt_s));
  assign adv_s    = ex_ready || !ex_valid_q;
  assign id_ready = adv_s && !hazard_s;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rs_data_d  = ex_rs_data_q;
    ex_rt_data_d  = ex_rt_data_q;
    ex_imm_d      = ex_imm_q;
    ex_dest_d     = ex_dest_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_memread_d  = ex_memread_q;
    ex_memwrite_d = ex_memwrite_q;
    ex_alu_op_d   = ex_alu_op_q;
    ex_illegal_d  = ex_illegal_q;
    stall_count_d = stall_count_q;
    if (if_valid && id_ready) begin
      ex_valid_d    = 1'b1;
      ex_rs_data_d  = dec_rs_data_s;
      ex_rt_data_d  = dec_rt_data_s;
      ex_imm_d      = dec_imm_s;
      ex_dest_d     = dec_dest_s;
      ex_regwrite_d = dec_rw_s;
      ex_memread_d  = dec_mr_s;
      ex_memwrite_d = dec_mw_s;
      ex_alu_op_d   = dec_alu_s;
      ex_illegal_d  = dec_ill_s;
    end else if (adv_s) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
    if (hazard_s && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_rs_data_q  <= {DATA_W{1'b0}};
      ex_rt_data_q  <= {DATA_W{1'b0}};
      ex_imm_q      <= {DATA_W{1'b0}};
      ex_dest_q     <= {ADDR_W{1'b0}};
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_alu_op_q   <= 3'd0;
      ex_illegal_q  <= 1'b0;
      stall_count_q <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rs_data_q  <= ex_rs_data_d;
      ex_rt_data_q  <= ex_rt_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_dest_q     <= ex_dest_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
      ex_alu_op_q   <= ex_alu_op_d;
      ex_illegal_q  <= ex_illegal_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs_data  = ex_rs_data_q;
  assign ex_rt_data  = ex_rt_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_dest     = ex_dest_q;
  assign ex_regwrite = ex_regwrite_q;
  assign ex_memread  = ex_memread_q;
  assign ex_memwrite = ex_memwrite_q;
  assign ex_alu_op   = ex_alu_op_q;
  assign ex_illegal  = ex_illegal_q;
  assign stall_count = stall_count_q;

endmodule
